// File: rtl/solver_pkg.sv
// Shared widths and FSM state encoding for the nonogram line pruner.
// Module parameters of line_pruner must not exceed the DEF_* limits below.
package solver_pkg;

    localparam int DEF_MAX_ROWS        = 11;
    localparam int DEF_MAX_COLS        = 11;
    localparam int DEF_MAX_NUM_OPTIONS = 84;

    localparam int LARGEST_DIM = (DEF_MAX_ROWS > DEF_MAX_COLS) ? DEF_MAX_ROWS : DEF_MAX_COLS;
    localparam int IDX_W       = $clog2(DEF_MAX_ROWS + DEF_MAX_COLS);
    localparam int CNT_W       = $clog2(DEF_MAX_NUM_OPTIONS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILTER = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/line_select.sv
// Gathers one row or column of the grid into a line-ordered slice, and scatters
// a line-ordered update back into row-major grid positions (the transpose).
module line_select
    import solver_pkg::*;
#(
    parameter int MAX_ROWS = DEF_MAX_ROWS,
    parameter int MAX_COLS = DEF_MAX_COLS
) (
    input  logic [MAX_ROWS*MAX_COLS-1:0] known_i,
    input  logic [MAX_ROWS*MAX_COLS-1:0] assigned_i,
    input  logic [IDX_W-1:0]             line_i,
    input  logic [IDX_W-1:0]             num_rows_i,
    input  logic [IDX_W-1:0]             num_cols_i,
    input  logic [LARGEST_DIM-1:0]       set_known_i,
    input  logic [LARGEST_DIM-1:0]       set_assigned_i,
    output logic [LARGEST_DIM-1:0]       slice_known_o,
    output logic [LARGEST_DIM-1:0]       slice_assigned_o,
    output logic [LARGEST_DIM-1:0]       in_range_o,
    output logic [MAX_ROWS*MAX_COLS-1:0] scat_known_o,
    output logic [MAX_ROWS*MAX_COLS-1:0] scat_assigned_o
);

    logic             is_row;
    logic [IDX_W-1:0] col_idx;

    // NOTE: every output gets a default before the loops so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        is_row           = (line_i < num_rows_i);
        col_idx          = line_i - num_rows_i;
        slice_known_o    = '0;
        slice_assigned_o = '0;
        in_range_o       = '0;
        scat_known_o     = '0;
        scat_assigned_o  = '0;
        for (int r = 0; r < MAX_ROWS; r++) begin
            for (int c = 0; c < MAX_COLS; c++) begin
                if (is_row && (r == int'(line_i)) && (c < int'(num_cols_i))) begin
                    slice_known_o[c]                = known_i[r*MAX_COLS+c];
                    slice_assigned_o[c]             = assigned_i[r*MAX_COLS+c];
                    in_range_o[c]                   = 1'b1;
                    scat_known_o[r*MAX_COLS+c]      = set_known_i[c];
                    scat_assigned_o[r*MAX_COLS+c]   = set_assigned_i[c];
                end else if (!is_row && (c == int'(col_idx)) && (r < int'(num_rows_i))) begin
                    slice_known_o[r]                = known_i[r*MAX_COLS+c];
                    slice_assigned_o[r]             = assigned_i[r*MAX_COLS+c];
                    in_range_o[r]                   = 1'b1;
                    scat_known_o[r*MAX_COLS+c]      = set_known_i[r];
                    scat_assigned_o[r*MAX_COLS+c]   = set_assigned_i[r];
                end
            end
        end
    end

endmodule

// File: rtl/line_pruner.sv
// Filters streamed line options against the known grid, forwards survivors and
// commits cells common to all survivors. Define LINE_PRUNER_STALL_EN to stop on a no-progress pass.
module line_pruner
    import solver_pkg::*;
#(
    parameter int MAX_ROWS        = DEF_MAX_ROWS,
    parameter int MAX_COLS        = DEF_MAX_COLS,
    parameter int MAX_NUM_OPTIONS = DEF_MAX_NUM_OPTIONS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [IDX_W-1:0]             num_rows,
    input  logic [IDX_W-1:0]             num_cols,
    input  logic                         opt_valid,
    output logic                         opt_ready,
    input  logic [IDX_W-1:0]             opt_line,
    input  logic [LARGEST_DIM-1:0]       opt_data,
    input  logic                         opt_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_line,
    output logic [LARGEST_DIM-1:0]       out_data,
    output logic                         cnt_valid,
    output logic [IDX_W-1:0]             cnt_line,
    output logic [CNT_W-1:0]             cnt_value,
    output logic [MAX_ROWS*MAX_COLS-1:0] known,
    output logic [MAX_ROWS*MAX_COLS-1:0] assigned,
    output logic                         solved,
    output logic                         contradiction,
    output logic                         stalled
);

    localparam int GRID = MAX_ROWS * MAX_COLS;

    state_e                 state_q, state_d;
    logic [GRID-1:0]        known_q, known_d, assigned_q, assigned_d;
    logic [GRID-1:0]        grid_mask, scat_known, scat_assigned, known_commit;
    logic [IDX_W-1:0]       rows_q, rows_d, cols_q, cols_d, line_q, line_d, sel_line;
    logic [IDX_W-1:0]       out_line_q, out_line_d, cnt_line_q, cnt_line_d;
    logic [LARGEST_DIM-1:0] always1_q, always1_d, always0_q, always0_d, out_data_q, out_data_d;
    logic [LARGEST_DIM-1:0] slice_known, slice_assigned, in_range, set_known_vec, set_assigned_vec;
    logic [CNT_W-1:0]       count_q, count_d, cnt_value_q, cnt_value_d;
    logic [IDX_W:0]         commit_cnt_q, commit_cnt_d, pass_len;
    logic                   line_active_q, line_active_d, out_valid_q, out_valid_d;
    logic                   cnt_valid_q, cnt_valid_d, solved_q, solved_d, contra_q, contra_d;
    logic                   progress_q, progress_d, progress_now;
    logic                   accept, consistent, solved_now;
`ifdef LINE_PRUNER_STALL_EN
    logic                   stalled_q, stalled_d;
`endif

    // The first beat of a line carries the index; later beats and COMMIT use the latched copy.
    assign sel_line  = (line_active_q || state_q == COMMIT) ? line_q : opt_line;
    assign opt_ready = (state_q == FILTER) && (!out_valid_q || out_ready);
    assign accept    = opt_valid && opt_ready;
    assign consistent = (((slice_assigned ^ opt_data) & slice_known & in_range) == '0);

    assign set_known_vec    = (always1_q | always0_q) & in_range;
    assign set_assigned_vec = always1_q & in_range;
    assign known_commit     = known_q | scat_known;
    assign solved_now       = &(known_commit | ~grid_mask);
    assign pass_len         = {1'b0, rows_q} + {1'b0, cols_q};

    line_select #(
        .MAX_ROWS (MAX_ROWS),
        .MAX_COLS (MAX_COLS)
    ) u_line_select (
        .known_i          (known_q),
        .assigned_i       (assigned_q),
        .line_i           (sel_line),
        .num_rows_i       (rows_q),
        .num_cols_i       (cols_q),
        .set_known_i      (set_known_vec),
        .set_assigned_i   (set_assigned_vec),
        .slice_known_o    (slice_known),
        .slice_assigned_o (slice_assigned),
        .in_range_o       (in_range),
        .scat_known_o     (scat_known),
        .scat_assigned_o  (scat_assigned)
    );

    always_comb begin
        grid_mask = '0;
        for (int r = 0; r < MAX_ROWS; r++) begin
            for (int c = 0; c < MAX_COLS; c++) begin
                grid_mask[r*MAX_COLS+c] = (r < int'(rows_q)) && (c < int'(cols_q));
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        known_d       = known_q;
        assigned_d    = assigned_q;
        rows_d        = rows_q;
        cols_d        = cols_q;
        line_d        = line_q;
        line_active_d = line_active_q;
        always1_d     = always1_q;
        always0_d     = always0_q;
        count_d       = count_q;
        out_valid_d   = out_valid_q;
        out_line_d    = out_line_q;
        out_data_d    = out_data_q;
        cnt_valid_d   = 1'b0;
        cnt_line_d    = cnt_line_q;
        cnt_value_d   = cnt_value_q;
        solved_d      = solved_q;
        contra_d      = contra_q;
        progress_d    = progress_q;
        commit_cnt_d  = commit_cnt_q;
        progress_now  = 1'b0;
`ifdef LINE_PRUNER_STALL_EN
        stalled_d     = stalled_q;
`endif

        if (out_ready) out_valid_d = 1'b0;
        if (accept) begin
            if (!line_active_q) line_d = opt_line;
            line_active_d = !opt_last;
            if (consistent) begin
                out_valid_d = 1'b1;
                out_line_d  = sel_line;
                out_data_d  = opt_data;
                count_d     = (count_q == CNT_W'(MAX_NUM_OPTIONS)) ? count_q : count_q + 1'b1;
                always1_d   = always1_q & opt_data;
                always0_d   = always0_q & ~opt_data;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = FILTER;
                    known_d       = '0;
                    assigned_d    = '0;
                    rows_d        = num_rows;
                    cols_d        = num_cols;
                    line_active_d = 1'b0;
                    always1_d     = '1;
                    always0_d     = '1;
                    count_d       = '0;
                    solved_d      = 1'b0;
                    contra_d      = 1'b0;
                    progress_d    = 1'b0;
                    commit_cnt_d  = '0;
`ifdef LINE_PRUNER_STALL_EN
                    stalled_d     = 1'b0;
`endif
                end
            end
            FILTER: begin
                if (accept && opt_last) state_d = COMMIT;
            end
            COMMIT: begin
                always1_d = '1;
                always0_d = '1;
                count_d   = '0;
                if (count_q == '0) begin
                    contra_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    known_d      = known_commit;
                    assigned_d   = (assigned_q & ~scat_known) | scat_assigned;
                    cnt_valid_d  = 1'b1;
                    cnt_line_d   = line_q;
                    cnt_value_d  = count_q;
                    progress_now = progress_q || ((scat_known & ~known_q) != '0);
                    if (solved_now) begin
                        solved_d = 1'b1;
                        state_d  = DONE;
                    end else if (commit_cnt_q + 1'b1 == pass_len) begin
                        commit_cnt_d = '0;
                        progress_d   = 1'b0;
`ifdef LINE_PRUNER_STALL_EN
                        if (!progress_now) begin
                            stalled_d = 1'b1;
                            state_d   = DONE;
                        end else begin
                            state_d   = FILTER;
                        end
`else
                        state_d      = FILTER;
`endif
                    end else begin
                        commit_cnt_d = commit_cnt_q + 1'b1;
                        progress_d   = progress_now;
                        state_d      = FILTER;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            known_q       <= '0;
            assigned_q    <= '0;
            rows_q        <= '0;
            cols_q        <= '0;
            line_q        <= '0;
            line_active_q <= 1'b0;
            always1_q     <= '1;
            always0_q     <= '1;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_line_q    <= '0;
            out_data_q    <= '0;
            cnt_valid_q   <= 1'b0;
            cnt_line_q    <= '0;
            cnt_value_q   <= '0;
            solved_q      <= 1'b0;
            contra_q      <= 1'b0;
            progress_q    <= 1'b0;
            commit_cnt_q  <= '0;
`ifdef LINE_PRUNER_STALL_EN
            stalled_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            known_q       <= known_d;
            assigned_q    <= assigned_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            line_q        <= line_d;
            line_active_q <= line_active_d;
            always1_q     <= always1_d;
            always0_q     <= always0_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_line_q    <= out_line_d;
            out_data_q    <= out_data_d;
            cnt_valid_q   <= cnt_valid_d;
            cnt_line_q    <= cnt_line_d;
            cnt_value_q   <= cnt_value_d;
            solved_q      <= solved_d;
            contra_q      <= contra_d;
            progress_q    <= progress_d;
            commit_cnt_q  <= commit_cnt_d;
`ifdef LINE_PRUNER_STALL_EN
            stalled_q     <= stalled_d;
`endif
        end
    end

    assign out_valid     = out_valid_q;
    assign out_line      = out_line_q;
    assign out_data      = out_data_q;
    assign cnt_valid     = cnt_valid_q;
    assign cnt_line      = cnt_line_q;
    assign cnt_value     = cnt_value_q;
    assign known         = known_q;
    assign assigned      = assigned_q;
    assign solved        = solved_q;
    assign contradiction = contra_q;
`ifdef LINE_PRUNER_STALL_EN
    assign stalled       = stalled_q;
`else
    assign stalled       = 1'b0;
`endif

endmodule

// File: tb/tb_line_pruner.sv
// Directed bench for line_pruner on a 3x3 active grid inside the default 11x11 array.
module tb_line_pruner;
    import solver_pkg::*;

    localparam int ROWS = DEF_MAX_ROWS;
    localparam int COLS = DEF_MAX_COLS;
    localparam int GRID = ROWS * COLS;

    logic                   clk = 1'b0;
    logic                   rst, start, opt_valid, opt_ready, opt_last;
    logic [IDX_W-1:0]       num_rows, num_cols, opt_line, out_line, cnt_line;
    logic [LARGEST_DIM-1:0] opt_data, out_data;
    logic                   out_valid, out_ready, cnt_valid;
    logic [CNT_W-1:0]       cnt_value;
    logic [GRID-1:0]        known, assigned;
    logic                   solved, contradiction, stalled;

    int n_checks = 0;
    int n_errors = 0;
    logic [GRID-1:0]        exp_k, exp_a;
    logic [IDX_W-1:0]       out_line_log[$];
    logic [LARGEST_DIM-1:0] out_data_log[$];
    int                     cnt_n = 0;
    logic [IDX_W-1:0]       last_cnt_line;
    logic [CNT_W-1:0]       last_cnt_value;
    int                     out_base, cnt_base;

    line_pruner dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_rows      (num_rows),
        .num_cols      (num_cols),
        .opt_valid     (opt_valid),
        .opt_ready     (opt_ready),
        .opt_line      (opt_line),
        .opt_data      (opt_data),
        .opt_last      (opt_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_line      (out_line),
        .out_data      (out_data),
        .cnt_valid     (cnt_valid),
        .cnt_line      (cnt_line),
        .cnt_value     (cnt_value),
        .known         (known),
        .assigned      (assigned),
        .solved        (solved),
        .contradiction (contradiction),
        .stalled       (stalled)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after posedge, so the negedge sees stable handshakes.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            out_line_log.push_back(out_line);
            out_data_log.push_back(out_data);
        end
        if (cnt_valid) begin
            cnt_n++;
            last_cnt_line  = cnt_line;
            last_cnt_value = cnt_value;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_solve(input int r, input int c);
        num_rows = IDX_W'(r);
        num_cols = IDX_W'(c);
        start    = 1'b1;
        idle(1);
        start    = 1'b0;
    endtask

    task automatic send_beat(input int line, input logic [2:0] data, input logic last);
        int waited = 0;
        opt_valid = 1'b1;
        opt_line  = IDX_W'(line);
        opt_data  = LARGEST_DIM'(data);
        opt_last  = last;
        forever begin
            @(negedge clk);
            if (opt_ready) break;
            waited++;
            if (waited > 50) begin
                check("opt_ready_timeout", 1'b0, 1'b1);
                opt_valid = 1'b0;
                idle(1);
                return;
            end
        end
        idle(1);
        opt_valid = 1'b0;
        opt_last  = 1'b0;
    endtask

    task automatic check_commit(input string tag, input int line, input int value);
        check({tag, "_cnt_pulses"}, 128'(cnt_n - cnt_base), 128'd1);
        check({tag, "_cnt_line"}, 128'(last_cnt_line), 128'(line));
        check({tag, "_cnt_value"}, 128'(last_cnt_value), 128'(value));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_rows = '0; num_cols = '0;
        opt_valid = 1'b0; opt_line = '0; opt_data = '0; opt_last = 1'b0;
        out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);

        check("reset_known", 128'(known), 128'd0);
        check("reset_assigned", 128'(assigned), 128'd0);
        check("reset_flags", {out_valid, cnt_valid, solved, contradiction, stalled, opt_ready}, 6'b0);

        // Single fully-determined option for row 0.
        start_solve(3, 3);
        check("filter_ready", opt_ready, 1'b1);
        cnt_base = cnt_n; out_base = out_data_log.size();
        send_beat(0, 3'b111, 1'b1);
        idle(2);
        exp_k = '0; exp_a = '0;
        exp_k[0 +: 3] = 3'b111; exp_a[0 +: 3] = 3'b111;
        check("row0_known", 128'(known), 128'(exp_k));
        check("row0_assigned", 128'(assigned), 128'(exp_a));
        check_commit("row0", 0, 1);
        check("row0_out_n", 128'(out_data_log.size() - out_base), 128'd1);
        check("row0_out_data", 128'(out_data_log[out_base]), 128'b111);

        // Two options for row 1 agree only on the middle cell.
        cnt_base = cnt_n; out_base = out_data_log.size();
        send_beat(1, 3'b110, 1'b0);
        send_beat(1, 3'b011, 1'b1);
        idle(2);
        exp_k[11 +: 3] = 3'b010; exp_a[11 +: 3] = 3'b010;
        check("row1_known", 128'(known), 128'(exp_k));
        check("row1_assigned", 128'(assigned), 128'(exp_a));
        check_commit("row1", 1, 2);
        check("row1_out_n", 128'(out_data_log.size() - out_base), 128'd2);
        check("row1_out_line", 128'(out_line_log[out_base + 1]), 128'd1);

        // Row 0 settled as 101, then re-filtered: 111 must be dropped.
        rst = 1'b1; idle(1); rst = 1'b0;
        start_solve(3, 3);
        send_beat(0, 3'b101, 1'b1);
        idle(2);
        cnt_base = cnt_n; out_base = out_data_log.size();
        send_beat(0, 3'b111, 1'b0);
        send_beat(0, 3'b101, 1'b1);
        idle(2);
        exp_k = '0; exp_a = '0;
        exp_k[0 +: 3] = 3'b111; exp_a[0 +: 3] = 3'b101;
        check("filt_known", 128'(known), 128'(exp_k));
        check_commit("filt", 0, 1);
        check("filt_out_n", 128'(out_data_log.size() - out_base), 128'd1);
        check("filt_out_data", 128'(out_data_log[out_base]), 128'b101);

        // Column 0 (line 3): top cell is 1, so 110 is dropped and 001 survives.
        cnt_base = cnt_n; out_base = out_data_log.size();
        send_beat(3, 3'b110, 1'b0);
        send_beat(3, 3'b001, 1'b1);
        idle(2);
        exp_k[11] = 1'b1; exp_k[22] = 1'b1;
        check("col0_known", 128'(known), 128'(exp_k));
        check("col0_assigned", 128'(assigned), 128'(exp_a));
        check_commit("col0", 3, 1);
        check("col0_out_line", 128'(out_line_log[out_base]), 128'd3);

        // Start during FILTER has no effect.
        start_solve(2, 2);
        check("start_ignored", 128'(known), 128'(exp_k));

        // Row 1 cell 0 is known 0; the only option sets it to 1.
        cnt_base = cnt_n; out_base = out_data_log.size();
        send_beat(1, 3'b111, 1'b1);
        idle(2);
        check("contra_flag", contradiction, 1'b1);
        check("contra_done", opt_ready, 1'b0);
        check("contra_grid", 128'(known), 128'(exp_k));
        check("contra_no_cnt", 128'(cnt_n - cnt_base), 128'd0);
        check("contra_no_out", 128'(out_data_log.size() - out_base), 128'd0);

        start_solve(3, 3);
        check("restart_known", 128'(known), 128'd0);
        check("restart_flags", {contradiction, solved, opt_ready}, 3'b001);

        // Back-pressure: second beat must wait while the first is unclaimed.
        cnt_base = cnt_n; out_base = out_data_log.size();
        out_ready = 1'b0;
        send_beat(0, 3'b101, 1'b0);
        opt_valid = 1'b1; opt_line = '0; opt_data = LARGEST_DIM'(3'b011); opt_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("bp_ready_low", opt_ready, 1'b0);
            check("bp_out_stable", {out_valid, 128'(out_data)}, {1'b1, 128'b101});
        end
        out_ready = 1'b1;
        idle(1);
        opt_valid = 1'b0; opt_last = 1'b0;
        idle(2);
        check("bp_out_n", 128'(out_data_log.size() - out_base), 128'd2);
        check("bp_order", {128'(out_data_log[out_base]), 128'(out_data_log[out_base + 1])},
              {128'b101, 128'b011});
        exp_k = '0; exp_a = '0;
        exp_k[0] = 1'b1; exp_a[0] = 1'b1;
        check("bp_known", 128'(known), 128'(exp_k));
        check_commit("bp", 0, 2);

        // Complete the 3x3 grid row by row; cells beyond 3x3 stay unknown.
        send_beat(0, 3'b111, 1'b1);
        idle(2);
        send_beat(1, 3'b000, 1'b1);
        idle(2);
        check("not_yet_solved", solved, 1'b0);
        send_beat(2, 3'b101, 1'b1);
        idle(2);
        exp_k = '0; exp_a = '0;
        exp_k[0 +: 3] = 3'b111; exp_k[11 +: 3] = 3'b111; exp_k[22 +: 3] = 3'b111;
        exp_a[0 +: 3] = 3'b111; exp_a[22 +: 3] = 3'b101;
        check("solved_flag", solved, 1'b1);
        check("solved_done", opt_ready, 1'b0);
        check("solved_known", 128'(known), 128'(exp_k));
        check("solved_assigned", 128'(assigned), 128'(exp_a));

        // A full pass of six ambiguous lines learns nothing.
        start_solve(3, 3);
        cnt_base = cnt_n; out_base = out_data_log.size();
        for (int l = 0; l < 6; l++) begin
            send_beat(l, 3'b100, 1'b0);
            send_beat(l, 3'b011, 1'b1);
            idle(2);
            if (l == 4) check("stall_early", stalled, 1'b0);
        end
        check("stall_cnt_pulses", 128'(cnt_n - cnt_base), 128'd6);
        check("stall_out_n", 128'(out_data_log.size() - out_base), 128'd12);
        check("stall_known", 128'(known), 128'd0);
        check("stall_last_value", 128'(last_cnt_value), 128'd2);
`ifdef LINE_PRUNER_STALL_EN
        check("stall_flag", stalled, 1'b1);
        check("stall_ready", opt_ready, 1'b0);
`else
        check("stall_flag", stalled, 1'b0);
        check("stall_ready", opt_ready, 1'b1);
`endif

        // Reset mid-line drops the pending out beat and the partial count.
        start_solve(3, 3);
        out_ready = 1'b0;
        send_beat(2, 3'b111, 1'b0);
        check("mid_pending", out_valid, 1'b1);
        rst = 1'b1;
        idle(1);
        check("mid_rst_out", {out_valid, opt_ready, cnt_valid}, 3'b000);
        rst = 1'b0;
        out_ready = 1'b1;
        start_solve(3, 3);
        cnt_base = cnt_n;
        send_beat(2, 3'b010, 1'b1);
        idle(2);
        exp_k = '0; exp_a = '0;
        exp_k[22 +: 3] = 3'b111; exp_a[22 +: 3] = 3'b010;
        check_commit("mid", 2, 1);
        check("mid_known", 128'(known), 128'(exp_k));
        check("mid_assigned", 128'(assigned), 128'(exp_a));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
